bcd_display_scan: RTL and testbench

- Downstream consumer of the cascaded single-digit BCD counters. It takes their packed 4-bit digit outputs and drives a time-multiplexed common-anode 7-segment display.
- Frame-synchronous shadow register prevents tearing while counters advance mid-scan.
- Contains refresh prescaler, digit-slot counter, BCD-to-segment decode and registered anode/segment outputs.

---
 rtl/bcd_disp_pkg.sv | 21 ++
 rtl/bcd_to_seg.sv | 30 +++
 rtl/bcd_display_scan.sv | 137 +++++++++++++
 tb/tb_bcd_display_scan.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display scanner.
// Holds the active-high 7-segment patterns ({g,f,e,d,c,b,a}, bit0 = a)
// and the BCD digit type used by the decoder and the scanner top.
package bcd_disp_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD-to-7-segment decode, active-high pattern.
// Codes 10..15 show a dash (segment g only).
// Ports:
//   bcd_i  - 4-bit BCD digit
//   seg_o  - segments {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner for packed BCD digits.
// A prescaler divides clk into digit slots; the slot counter walks the
// digits, and a shadow copy of the digits/decimal points is taken at the
// end of the last slot so every frame shows one coherent snapshot.
// All outputs are registered (1-cycle latency from idx/shadow).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is never blanked; dp still follows the shadow dp).
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high
//   bcd_in    - packed digits, [3:0] = digit 0
//   dp_in     - decimal point request per digit, 1 = lit
//   seg       - segments {g,f,e,d,c,b,a} at active level
//   dp        - decimal point of active digit at active level
//   an        - one-hot anode select at active level
//   digit_sel - index of digit currently driven
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       bcd_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_sel
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF_LVL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF_LVL  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]       shadow_bcd_q, shadow_bcd_d;
   logic [NUM_DIGITS-1:0]            shadow_dp_q, shadow_dp_d;
   logic [6:0]                       seg_q, seg_d;
   logic                             dp_q, dp_d;
   logic [NUM_DIGITS-1:0]            an_q, an_d;
   logic [IDX_W-1:0]                 sel_q, sel_d;

   logic                             tick;
   bcd_digit_t                       cur_digit;
   logic [6:0]                       cur_pat;
   logic [6:0]                       vis_pat;
   logic [NUM_DIGITS-1:0]            blank;

   assign cur_digit = shadow_bcd_q[idx_q];

   bcd_to_seg u_dec (
      .bcd_i (cur_digit),
      .seg_o (cur_pat)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the most significant digit; a digit is blanked while
   // it and everything above it is zero.
   always_comb begin
      logic lead;
      lead  = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lead     = lead & (shadow_bcd_q[i] == 4'd0);
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      tick         = (cnt_q == CNT_LAST);
      cnt_d        = tick ? '0 : cnt_q + 1'b1;
      idx_d        = idx_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;

      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         // Snapshot at the end of the last slot so the next frame is coherent.
         if (idx_q == IDX_LAST) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
         end
      end

      vis_pat = blank[idx_q] ? SEG_OFF : cur_pat;
      seg_d   = (SEG_ACTIVE_LOW != 0) ? ~vis_pat : vis_pat;
      dp_d    = shadow_dp_q[idx_q] ^ DP_OFF_LVL;

      an_d = AN_OFF_LVL;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) an_d[i] = ~AN_OFF_LVL[i];
      end

      sel_d = idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         seg_q        <= SEG_OFF_LVL;
         dp_q         <= DP_OFF_LVL;
         an_q         <= AN_OFF_LVL;
         sel_q        <= '0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         sel_q        <= sel_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (4 digits, 4 clocks per slot,
// active-low segments and anodes). Expected outputs come from a timeline
// model: the output after edge t (counted from reset release) shows slot
// ((t-1)/RDIV)%ND of the snapshot taken at the most recent frame boundary.
module tb_bcd_display_scan;

   localparam int ND   = 4;
   localparam int RDIV = 4;
   localparam int FRAME = ND * RDIV;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  digit_sel;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;

   logic [15:0] bcd_hist [0:8191];
   logic [3:0]  dp_hist  [0:8191];
   logic [6:0]  seg_tab  [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic [6:0] exp_seg;
   logic       exp_dp;
   logic [3:0] exp_an;
   logic [1:0] exp_sel;

   bcd_display_scan #(
      .NUM_DIGITS     (ND),
      .REFRESH_DIV    (RDIV),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bcd_in    (bcd_in),
      .dp_in     (dp_in),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   task automatic compute_exp(input int te);
      int          k, slot, f, d;
      logic [15:0] snap;
      logic [3:0]  sdp;
      logic [6:0]  pat;
      k    = te - 1;
      slot = (k / RDIV) % ND;
      f    = k / FRAME;
      snap = (f == 0) ? 16'h0 : bcd_hist[f * FRAME];
      sdp  = (f == 0) ? 4'h0  : dp_hist[f * FRAME];
      d    = int'((snap >> (4 * slot)) & 16'hF);
      pat  = (d < 10) ? seg_tab[d] : 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && (snap >> (4 * slot)) == 16'h0) pat = 7'h00;
`endif
      exp_seg = ~pat;
      exp_dp  = ~sdp[slot];
      exp_an  = ~(4'b0001 << slot);
      exp_sel = 2'(slot);
   endtask

   task automatic step();
      logic r;
      @(posedge clk);
      r = reset;
      if (r) t = 0;
      else begin
         t++;
         bcd_hist[t] = bcd_in;
         dp_hist[t]  = dp_in;
      end
      #1;
      if (r) begin
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_sel = 2'd0;
      end else begin
         compute_exp(t);
      end
      n_checks++;
      assert (seg === exp_seg) else begin
         n_fail++;
         $error("FAIL seg t=%0d observed=%h expected=%h", t, seg, exp_seg);
      end
      n_checks++;
      assert (dp === exp_dp) else begin
         n_fail++;
         $error("FAIL dp t=%0d observed=%b expected=%b", t, dp, exp_dp);
      end
      n_checks++;
      assert (an === exp_an) else begin
         n_fail++;
         $error("FAIL an t=%0d observed=%b expected=%b", t, an, exp_an);
      end
      n_checks++;
      assert (digit_sel === exp_sel) else begin
         n_fail++;
         $error("FAIL digit_sel t=%0d observed=%0d expected=%0d", t, digit_sel, exp_sel);
      end
   endtask

   initial begin
      logic [15:0] v;
      reset  = 1'b1;
      bcd_in = 16'h1234;
      dp_in  = 4'b0000;
      repeat (3) step();

      reset = 1'b0;
      dp_in = 4'b0100;
      repeat (40) step();

      // Change digits mid-frame while digit 1 is on display.
      for (int i = 0; i < 20 && exp_sel != 2'd1; i++) step();
      bcd_in = 16'h5678;
      repeat (40) step();

      bcd_in = 16'h00A9;
      dp_in  = 4'b0001;
      repeat (36) step();

      // Mid-scan reset while digit 2 is on display.
      for (int i = 0; i < 20 && exp_sel != 2'd2; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (24) step();

      for (int n = 0; n < 30; n++) begin
         for (int j = 0; j < 4; j++)
            v[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bcd_in = v;
         dp_in  = 4'($urandom_range(0, 15));
         repeat ($urandom_range(1, 20)) step();
      end

      bcd_in = 16'h0070;
      dp_in  = 4'b0000;
      repeat (36) step();
      bcd_in = 16'h0000;
      repeat (36) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
